// File: rtl/multicycle_control.sv
// -----------------------------------------------------------------------------
// multicycle_control
//
// Control FSM for the multi-cycle core. Each instruction is sequenced through
// fetch, decode, execute / memory and write-back states. The FSM drives the
// datapath strobes and mux selects for every state. It waits on the memory
// ready handshake under a watchdog, and it counts retired instructions.
//
// Optional feature macro: MULTICYCLE_CONTROL_BLT_BGT_EN
//   defined   : opcodes 1011/1100 decode to blt/bgt branches
//   undefined : 1011/1100 are illegal, and the lt flag is ignored
//
// Ports
//   clk, reset      clock, synchronous active-high reset
//   opcode          IR opcode field (only sampled in DECODE)
//   mem_ready       memory access completes this cycle
//   zero, lt        ALU equal / signed-less-than flags
//   pc_write, ir_write, iord, mem_read, mem_write, reg_write, alu_src_a
//                   single-bit datapath strobes
//   pc_src, reg_dst, mem_to_reg, alu_op, alu_src_b
//                   2-bit mux selects / ALU operation class
//   illegal_op      one-cycle pulse after decoding an undefined opcode
//   mem_timeout     sticky watchdog error, cleared only by reset
//   instr_count     retired-instruction counter, wraps
// -----------------------------------------------------------------------------
module multicycle_control #(
   parameter int OPCODE_W    = 4,
   parameter int MEM_TIMEOUT = 15,
   parameter int CNT_W       = 16
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [OPCODE_W-1:0] opcode,
   input  logic                mem_ready,
   input  logic                zero,
   input  logic                lt,
   output logic                pc_write,
   output logic                ir_write,
   output logic                iord,
   output logic                mem_read,
   output logic                mem_write,
   output logic                reg_write,
   output logic                alu_src_a,
   output logic [1:0]          pc_src,
   output logic [1:0]          reg_dst,
   output logic [1:0]          mem_to_reg,
   output logic [1:0]          alu_op,
   output logic [1:0]          alu_src_b,
   output logic                illegal_op,
   output logic                mem_timeout,
   output logic [CNT_W-1:0]    instr_count
);

   localparam logic [3:0] OP_R    = 4'b0000;
   localparam logic [3:0] OP_ADDI = 4'b0001;
   localparam logic [3:0] OP_ANDI = 4'b0010;
   localparam logic [3:0] OP_ORI  = 4'b0011;
   localparam logic [3:0] OP_SUBI = 4'b0100;
   localparam logic [3:0] OP_LHW  = 4'b0111;
   localparam logic [3:0] OP_SHW  = 4'b1000;
   localparam logic [3:0] OP_BEQ  = 4'b1001;
   localparam logic [3:0] OP_BNE  = 4'b1010;
   localparam logic [3:0] OP_BLT  = 4'b1011;
   localparam logic [3:0] OP_BGT  = 4'b1100;
   localparam logic [3:0] OP_JUMP = 4'b1111;

   // wait_cnt never exceeds MEM_TIMEOUT-1, so clog2(MEM_TIMEOUT) bits suffice
   localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

   typedef enum logic [3:0] {
      S_FETCH,
      S_DECODE,
      S_EXEC,
      S_ALU_WB,
      S_MEM_ADDR,
      S_MEM_RD,
      S_MEM_WB,
      S_MEM_WR,
      S_BRANCH,
      S_JUMP
   } state_t;

   state_t             state_reg, state_next;
   logic [3:0]         op_reg;            // opcode latched in DECODE
   logic [WAIT_W-1:0]  wait_cnt_reg, wait_cnt_next;
   logic [CNT_W-1:0]   instr_count_reg;
   logic               illegal_reg;
   logic               timeout_reg;

   logic               op_high_nz;
   state_t             dec_state;
   logic               dec_illegal;
   logic               branch_taken;
   logic               in_wait;
   logic               wait_last;
   logic               timeout_hit;
   logic               retire;
   logic               illegal_hit;

   // Opcode bits above bit 3 make any opcode illegal
   generate
      if (OPCODE_W > 4) begin : g_wide_op
         assign op_high_nz = |opcode[OPCODE_W-1:4];
      end else begin : g_narrow_op
         assign op_high_nz = 1'b0;
      end
   endgenerate

`ifndef MULTICYCLE_CONTROL_BLT_BGT_EN
   // lt only matters when the blt/bgt branches exist
   logic unused_lt;
   assign unused_lt = lt;
`endif

   // DECODE dispatch works on the live opcode; op_reg is not valid until
   // the following cycle.
   always_comb begin
      dec_state   = S_FETCH;
      dec_illegal = 1'b0;
      case (opcode[3:0])
         OP_R, OP_ADDI, OP_ANDI, OP_ORI, OP_SUBI: dec_state = S_EXEC;
         OP_LHW, OP_SHW:                          dec_state = S_MEM_ADDR;
         OP_BEQ, OP_BNE:                          dec_state = S_BRANCH;
`ifdef MULTICYCLE_CONTROL_BLT_BGT_EN
         OP_BLT, OP_BGT:                          dec_state = S_BRANCH;
`endif
         OP_JUMP:                                 dec_state = S_JUMP;
         default:                                 dec_illegal = 1'b1;
      endcase
      if (op_high_nz) begin
         dec_state   = S_FETCH;
         dec_illegal = 1'b1;
      end
   end

   always_comb begin
      branch_taken = 1'b0;
      case (op_reg)
         OP_BEQ: branch_taken = zero;
         OP_BNE: branch_taken = !zero;
`ifdef MULTICYCLE_CONTROL_BLT_BGT_EN
         OP_BLT: branch_taken = lt;
         OP_BGT: branch_taken = !lt && !zero;
`endif
         default: branch_taken = 1'b0;
      endcase
   end

   assign in_wait   = (state_reg == S_FETCH) || (state_reg == S_MEM_RD) ||
                      (state_reg == S_MEM_WR);
   assign wait_last = (wait_cnt_reg == WAIT_LAST);

   // Next state and Moore outputs; pc_write/ir_write in FETCH and pc_write
   // in BRANCH are the only input-dependent outputs.
   always_comb begin
      state_next  = state_reg;
      pc_write    = 1'b0;
      ir_write    = 1'b0;
      iord        = 1'b0;
      mem_read    = 1'b0;
      mem_write   = 1'b0;
      reg_write   = 1'b0;
      alu_src_a   = 1'b0;
      pc_src      = 2'b00;
      reg_dst     = 2'b00;
      mem_to_reg  = 2'b00;
      alu_op      = 2'b00;
      alu_src_b   = 2'b00;
      timeout_hit = 1'b0;
      retire      = 1'b0;
      illegal_hit = 1'b0;

      case (state_reg)
         S_FETCH: begin
            mem_read  = 1'b1;
            alu_src_b = 2'b01;
            if (mem_ready) begin
               ir_write   = 1'b1;
               pc_write   = 1'b1;
               state_next = S_DECODE;
            end else if (wait_last) begin
               timeout_hit = 1'b1;
            end
         end
         S_DECODE: begin
            alu_src_b   = 2'b11;
            state_next  = dec_state;
            illegal_hit = dec_illegal;
         end
         S_EXEC: begin
            alu_src_a = 1'b1;
            case (op_reg)
               OP_R: begin
                  alu_src_b = 2'b00;
                  alu_op    = 2'b10;
               end
               OP_ADDI, OP_SUBI: begin
                  alu_src_b = 2'b10;
                  alu_op    = 2'b00;
               end
               OP_ANDI, OP_ORI: begin
                  alu_src_b = 2'b10;
                  alu_op    = 2'b11;
               end
               default: ;
            endcase
            state_next = S_ALU_WB;
         end
         S_ALU_WB: begin
            reg_write  = 1'b1;
            reg_dst    = (op_reg == OP_R) ? 2'b01 : 2'b00;
            retire     = 1'b1;
            state_next = S_FETCH;
         end
         S_MEM_ADDR: begin
            alu_src_a  = 1'b1;
            alu_src_b  = 2'b10;
            state_next = (op_reg == OP_LHW) ? S_MEM_RD : S_MEM_WR;
         end
         S_MEM_RD: begin
            iord     = 1'b1;
            mem_read = 1'b1;
            if (mem_ready) begin
               state_next = S_MEM_WB;
            end else if (wait_last) begin
               timeout_hit = 1'b1;
               state_next  = S_FETCH;
            end
         end
         S_MEM_WB: begin
            reg_write  = 1'b1;
            mem_to_reg = 2'b01;
            retire     = 1'b1;
            state_next = S_FETCH;
         end
         S_MEM_WR: begin
            iord      = 1'b1;
            mem_write = 1'b1;
            if (mem_ready) begin
               retire     = 1'b1;
               state_next = S_FETCH;
            end else if (wait_last) begin
               timeout_hit = 1'b1;
               state_next  = S_FETCH;
            end
         end
         S_BRANCH: begin
            alu_src_a  = 1'b1;
            alu_op     = 2'b01;
            pc_src     = 2'b01;
            pc_write   = branch_taken;
            retire     = 1'b1;
            state_next = S_FETCH;
         end
         S_JUMP: begin
            pc_src     = 2'b10;
            pc_write   = 1'b1;
            retire     = 1'b1;
            state_next = S_FETCH;
         end
         default: state_next = S_FETCH;
      endcase
   end

   // The counter restarts on every state change (mem_ready high leaves the
   // wait state) and on a timeout, so it is always zero on entry.
   always_comb begin
      wait_cnt_next = '0;
      if (in_wait && !mem_ready && !timeout_hit) begin
         wait_cnt_next = wait_cnt_reg + WAIT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg       <= S_FETCH;
         op_reg          <= '0;
         wait_cnt_reg    <= '0;
         instr_count_reg <= '0;
         illegal_reg     <= 1'b0;
         timeout_reg     <= 1'b0;
      end else begin
         state_reg    <= state_next;
         wait_cnt_reg <= wait_cnt_next;
         illegal_reg  <= illegal_hit;
         if (state_reg == S_DECODE) begin
            op_reg <= opcode[3:0];
         end
         if (timeout_hit) begin
            timeout_reg <= 1'b1;
         end
         if (retire) begin
            instr_count_reg <= instr_count_reg + CNT_W'(1);
         end
      end
   end

   assign illegal_op  = illegal_reg;
   assign mem_timeout = timeout_reg;
   assign instr_count = instr_count_reg;

endmodule

// File: tb/tb_multicycle_control.sv
// -----------------------------------------------------------------------------
// tb_multicycle_control
//
// Self-checking bench for multicycle_control. A table of per-cycle records
// {opcode, mem_ready, zero, lt, expected outputs} walks through every
// instruction class; hand-written sequences cover the watchdog, ready/timeout
// priority and reset in the middle of a store. Honors
// MULTICYCLE_CONTROL_BLT_BGT_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_multicycle_control;

   // Expected output vector layout:
   // {pc_write, ir_write, iord, mem_read, mem_write, reg_write, alu_src_a,
   //  pc_src[1:0], reg_dst[1:0], mem_to_reg[1:0], alu_op[1:0], alu_src_b[1:0]}
   localparam logic [16:0] F      = 17'b0_0_0_1_0_0_0_00_00_00_00_01;
   localparam logic [16:0] F_DONE = 17'b1_1_0_1_0_0_0_00_00_00_00_01;
   localparam logic [16:0] D      = 17'b0_0_0_0_0_0_0_00_00_00_00_11;
   localparam logic [16:0] EX_R   = 17'b0_0_0_0_0_0_1_00_00_00_10_00;
   localparam logic [16:0] EX_I   = 17'b0_0_0_0_0_0_1_00_00_00_00_10;
   localparam logic [16:0] EX_L   = 17'b0_0_0_0_0_0_1_00_00_00_11_10;
   localparam logic [16:0] WB_R   = 17'b0_0_0_0_0_1_0_00_01_00_00_00;
   localparam logic [16:0] WB_I   = 17'b0_0_0_0_0_1_0_00_00_00_00_00;
   localparam logic [16:0] MA     = 17'b0_0_0_0_0_0_1_00_00_00_00_10;
   localparam logic [16:0] MRD    = 17'b0_0_1_1_0_0_0_00_00_00_00_00;
   localparam logic [16:0] MWB    = 17'b0_0_0_0_0_1_0_00_00_01_00_00;
   localparam logic [16:0] MWR    = 17'b0_0_1_0_1_0_0_00_00_00_00_00;
   localparam logic [16:0] BR     = 17'b0_0_0_0_0_0_1_01_00_00_01_00;
   localparam logic [16:0] BR_T   = 17'b1_0_0_0_0_0_1_01_00_00_01_00;
   localparam logic [16:0] JMP    = 17'b1_0_0_0_0_0_0_10_00_00_00_00;

   logic        clk;
   logic        reset;
   logic [3:0]  opcode;
   logic        mem_ready;
   logic        zero;
   logic        lt;
   logic        pc_write, ir_write, iord, mem_read, mem_write, reg_write, alu_src_a;
   logic [1:0]  pc_src, reg_dst, mem_to_reg, alu_op, alu_src_b;
   logic        illegal_op;
   logic        mem_timeout;
   logic [15:0] instr_count;
   logic [16:0] act_out;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [3:0]  op;
      logic        rdy;
      logic        z;
      logic        lt;
      logic [16:0] out;
      logic        ill;
      logic [15:0] cnt;
   } vec_t;

   vec_t vecs[$];

   multicycle_control #(
      .OPCODE_W    (4),
      .MEM_TIMEOUT (15),
      .CNT_W       (16)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .opcode      (opcode),
      .mem_ready   (mem_ready),
      .zero        (zero),
      .lt          (lt),
      .pc_write    (pc_write),
      .ir_write    (ir_write),
      .iord        (iord),
      .mem_read    (mem_read),
      .mem_write   (mem_write),
      .reg_write   (reg_write),
      .alu_src_a   (alu_src_a),
      .pc_src      (pc_src),
      .reg_dst     (reg_dst),
      .mem_to_reg  (mem_to_reg),
      .alu_op      (alu_op),
      .alu_src_b   (alu_src_b),
      .illegal_op  (illegal_op),
      .mem_timeout (mem_timeout),
      .instr_count (instr_count)
   );

   assign act_out = {pc_write, ir_write, iord, mem_read, mem_write, reg_write,
                     alu_src_a, pc_src, reg_dst, mem_to_reg, alu_op, alu_src_b};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic add(input logic [3:0] op, input logic rdy, input logic z,
                      input logic l, input logic [16:0] out, input logic ill,
                      input logic [15:0] cnt);
      vec_t v;
      v.op  = op;
      v.rdy = rdy;
      v.z   = z;
      v.lt  = l;
      v.out = out;
      v.ill = ill;
      v.cnt = cnt;
      vecs.push_back(v);
   endtask

   // Compare every output at the falling edge against the expected record
   task automatic check(input string name, input logic [16:0] eout,
                        input logic eill, input logic eto, input logic [15:0] ecnt);
      checks++;
      if ({act_out, illegal_op, mem_timeout, instr_count} !== {eout, eill, eto, ecnt}) begin
         errors++;
         $display("FAIL %s: got outs=%b ill=%b to=%b cnt=%0d, required outs=%b ill=%b to=%b cnt=%0d",
                  name, act_out, illegal_op, mem_timeout, instr_count, eout, eill, eto, ecnt);
      end else begin
         $display("ok   %s: outs=%b ill=%b to=%b cnt=%0d",
                  name, act_out, illegal_op, mem_timeout, instr_count);
      end
   endtask

   // Entered just after a rising edge; leaves just after the next one
   task automatic cycle(input string name, input logic [3:0] op, input logic rdy,
                        input logic z, input logic l, input logic [16:0] eout,
                        input logic eill, input logic eto, input logic [15:0] ecnt);
      opcode    = op;
      mem_ready = rdy;
      zero      = z;
      lt        = l;
      @(negedge clk);
      check(name, eout, eill, eto, ecnt);
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset     = 1'b1;
      opcode    = 4'd0;
      mem_ready = 1'b0;
      zero      = 1'b0;
      lt        = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   initial begin
      // ---------------- instruction table ----------------
      // R-type
      add(4'd0,  1, 0, 0, F_DONE, 0, 0);
      add(4'd0,  1, 0, 0, D,      0, 0);
      add(4'd0,  1, 0, 0, EX_R,   0, 0);
      add(4'd0,  1, 0, 0, WB_R,   0, 0);
      // addi
      add(4'd1,  1, 0, 0, F_DONE, 0, 1);
      add(4'd1,  1, 0, 0, D,      0, 1);
      add(4'd1,  1, 0, 0, EX_I,   0, 1);
      add(4'd1,  1, 0, 0, WB_I,   0, 1);
      // andi
      add(4'd2,  1, 0, 0, F_DONE, 0, 2);
      add(4'd2,  1, 0, 0, D,      0, 2);
      add(4'd2,  1, 0, 0, EX_L,   0, 2);
      add(4'd2,  1, 0, 0, WB_I,   0, 2);
      // ori
      add(4'd3,  1, 0, 0, F_DONE, 0, 3);
      add(4'd3,  1, 0, 0, D,      0, 3);
      add(4'd3,  1, 0, 0, EX_L,   0, 3);
      add(4'd3,  1, 0, 0, WB_I,   0, 3);
      // subi
      add(4'd4,  1, 0, 0, F_DONE, 0, 4);
      add(4'd4,  1, 0, 0, D,      0, 4);
      add(4'd4,  1, 0, 0, EX_I,   0, 4);
      add(4'd4,  1, 0, 0, WB_I,   0, 4);
      // lhw: one fetch wait, three MEM_RD waits
      add(4'd7,  0, 0, 0, F,      0, 5);
      add(4'd7,  1, 0, 0, F_DONE, 0, 5);
      add(4'd7,  1, 0, 0, D,      0, 5);
      add(4'd7,  1, 0, 0, MA,     0, 5);
      add(4'd7,  0, 0, 0, MRD,    0, 5);
      add(4'd7,  0, 0, 0, MRD,    0, 5);
      add(4'd7,  0, 0, 0, MRD,    0, 5);
      add(4'd7,  1, 0, 0, MRD,    0, 5);
      add(4'd7,  1, 0, 0, MWB,    0, 5);
      // shw with one MEM_WR wait
      add(4'd8,  1, 0, 0, F_DONE, 0, 6);
      add(4'd8,  1, 0, 0, D,      0, 6);
      add(4'd8,  1, 0, 0, MA,     0, 6);
      add(4'd8,  0, 0, 0, MWR,    0, 6);
      add(4'd8,  1, 0, 0, MWR,    0, 6);
      // beq zero=1 taken, bne zero=1 not taken, bne zero=0 taken, beq zero=0 not
      add(4'd9,  1, 1, 0, F_DONE, 0, 7);
      add(4'd9,  1, 1, 0, D,      0, 7);
      add(4'd9,  1, 1, 0, BR_T,   0, 7);
      add(4'd10, 1, 1, 0, F_DONE, 0, 8);
      add(4'd10, 1, 1, 0, D,      0, 8);
      add(4'd10, 1, 1, 0, BR,     0, 8);
      add(4'd10, 1, 0, 0, F_DONE, 0, 9);
      add(4'd10, 1, 0, 0, D,      0, 9);
      add(4'd10, 1, 0, 0, BR_T,   0, 9);
      add(4'd9,  1, 0, 0, F_DONE, 0, 10);
      add(4'd9,  1, 0, 0, D,      0, 10);
      add(4'd9,  1, 0, 0, BR,     0, 10);
      // jump
      add(4'd15, 1, 0, 0, F_DONE, 0, 11);
      add(4'd15, 1, 0, 0, D,      0, 11);
      add(4'd15, 1, 0, 0, JMP,    0, 11);
      // illegal 0101 then 1110: pulse in the following FETCH, count frozen
      add(4'd5,  1, 0, 0, F_DONE, 0, 12);
      add(4'd5,  1, 0, 0, D,      0, 12);
      add(4'd14, 1, 0, 0, F_DONE, 1, 12);
      add(4'd14, 1, 0, 0, D,      0, 12);
      add(4'd12, 1, 0, 0, F_DONE, 1, 12);
      add(4'd12, 1, 0, 0, D,      0, 12);
`ifdef MULTICYCLE_CONTROL_BLT_BGT_EN
      add(4'd12, 1, 0, 0, BR_T,   0, 12);   // bgt lt=0 zero=0 taken
      add(4'd11, 1, 0, 0, F_DONE, 0, 13);
      add(4'd11, 1, 0, 0, D,      0, 13);
      add(4'd11, 1, 0, 0, BR,     0, 13);   // blt lt=0 not taken
      add(4'd11, 1, 0, 1, F_DONE, 0, 14);
      add(4'd11, 1, 0, 1, D,      0, 14);
      add(4'd11, 1, 0, 1, BR_T,   0, 14);   // blt lt=1 taken
      add(4'd12, 1, 0, 1, F_DONE, 0, 15);
      add(4'd12, 1, 0, 1, D,      0, 15);
      add(4'd12, 1, 0, 1, BR,     0, 15);   // bgt lt=1 not taken
      add(4'd0,  1, 0, 0, F_DONE, 0, 16);
      add(4'd0,  1, 0, 0, D,      0, 16);
      add(4'd0,  1, 0, 0, EX_R,   0, 16);
      add(4'd0,  1, 0, 0, WB_R,   0, 16);
      add(4'd0,  0, 0, 0, F,      0, 17);
`else
      add(4'd11, 1, 0, 1, F_DONE, 1, 12);   // 1100 was illegal
      add(4'd11, 1, 0, 1, D,      0, 12);
      add(4'd0,  1, 0, 0, F_DONE, 1, 12);   // 1011 was illegal
      add(4'd0,  1, 0, 0, D,      0, 12);
      add(4'd0,  1, 0, 0, EX_R,   0, 12);
      add(4'd0,  1, 0, 0, WB_R,   0, 12);
      add(4'd0,  0, 0, 0, F,      0, 13);
`endif

      // ---------------- fetch watchdog ----------------
      do_reset();
      for (int c = 1; c <= 15; c++) begin
         cycle($sformatf("fetch_wait_%0d", c), 4'd0, 0, 0, 0, F, 0, 0, 16'd0);
      end
      cycle("fetch_timeout_set", 4'd0, 0, 0, 0, F, 0, 1, 16'd0);
      cycle("timeout_sticky",    4'd0, 1, 0, 0, F_DONE, 0, 1, 16'd0);
      cycle("decode_after_to",   4'd0, 1, 0, 0, D, 0, 1, 16'd0);

      // ---------------- ready wins over timeout ----------------
      do_reset();
      cycle("reset_clears_to", 4'd0, 0, 0, 0, F, 0, 0, 16'd0);
      repeat (13) begin
         opcode = 4'd0; mem_ready = 1'b0;
         @(posedge clk);
         #1;
      end
      cycle("ready_at_limit", 4'd0, 1, 0, 0, F_DONE, 0, 0, 16'd0);
      cycle("no_timeout",     4'd0, 1, 0, 0, D,      0, 0, 16'd0);

      // ---------------- MEM_WR watchdog, no retire ----------------
      do_reset();
      cycle("shw_fetch", 4'd8, 1, 0, 0, F_DONE, 0, 0, 16'd0);
      cycle("shw_dec",   4'd8, 1, 0, 0, D,      0, 0, 16'd0);
      cycle("shw_addr",  4'd8, 1, 0, 0, MA,     0, 0, 16'd0);
      repeat (14) begin
         mem_ready = 1'b0;
         @(posedge clk);
         #1;
      end
      cycle("memwr_last_wait", 4'd8, 0, 0, 0, MWR, 0, 0, 16'd0);
      cycle("memwr_timeout",   4'd8, 0, 0, 0, F,   0, 1, 16'd0);

      // ---------------- reset in MEM_WR ----------------
      do_reset();
      cycle("rst_shw_fetch", 4'd8, 1, 0, 0, F_DONE, 0, 0, 16'd0);
      cycle("rst_shw_dec",   4'd8, 1, 0, 0, D,      0, 0, 16'd0);
      cycle("rst_shw_addr",  4'd8, 1, 0, 0, MA,     0, 0, 16'd0);
      opcode = 4'd8; mem_ready = 1'b1;
      @(negedge clk);
      check("rst_in_memwr", MWR, 0, 0, 16'd0);
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      cycle("after_rst_edge", 4'd8, 0, 0, 0, F, 0, 0, 16'd0);

      // ---------------- table run ----------------
      do_reset();
      foreach (vecs[i]) begin
         cycle($sformatf("vec_%0d_op%0d", i, vecs[i].op), vecs[i].op, vecs[i].rdy,
               vecs[i].z, vecs[i].lt, vecs[i].out, vecs[i].ill, 1'b0, vecs[i].cnt);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Multi-cycle successor to the single-cycle opcode decoder. It sequences each instruction through fetch, decode, execute, memory and write-back states, and drives datapath strobes per state. It waits on a memory ready handshake with a watchdog, adds blt/bgt branches, and counts retired instructions. It sits between the instruction register and the shared-memory datapath of the multi-cycle core.

## Interface
- OPCODE_W, 4, opcode width (≥4); any nonzero bit above bit 3 makes the opcode illegal
- MEM_TIMEOUT, 15, maximum low-ready cycles tolerated in a memory wait state (≥1)
- CNT_W, 16, retired-instruction counter width
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- opcode  in  OPCODE_W  IR opcode field
- mem_ready  in  1  memory access completes this cycle
- zero, lt  in  1 each  ALU equal / signed-less-than flags
- pc_write, ir_write, iord, mem_read, mem_write, reg_write, alu_src_a  out  1 each  datapath strobes
- pc_src, reg_dst, mem_to_reg, alu_op, alu_src_b  out  2 each  mux selects / ALU class
- illegal_op  out  1  one-cycle pulse on undefined opcode
- mem_timeout  out  1  sticky watchdog error
- instr_count  out  CNT_W  retired instructions, wraps

## Operation
- Opcode map: R=0000, addi=0001, andi=0010, ori=0011, subi=0100, lhw=0111, shw=1000, beq=1001, bne=1010, blt=1011, bgt=1100, jump=1111. All others are illegal.
- The opcode is latched into op_q in DECODE. Later states use op_q only.
- Any output not listed for a state is 0.
- FETCH:
  - Drives iord=0, mem_read=1, alu_src_a=0, alu_src_b=01, alu_op=00, pc_src=00.
  - On mem_ready, pulses ir_write=1 and pc_write=1, then goes to DECODE.
- DECODE:
  - Drives alu_src_a=0, alu_src_b=11, alu_op=00 (branch target).
  - Next state: R/addi/subi/andi/ori→EXEC; lhw/shw→MEM_ADDR; beq/bne/blt/bgt→BRANCH; jump→JUMP.
  - Illegal opcode → FETCH, with illegal_op high the next cycle.
- EXEC:
  - Drives alu_src_a=1.
  - R: alu_src_b=00, alu_op=10. addi/subi: alu_src_b=10, alu_op=00. andi/ori: alu_src_b=10, alu_op=11.
  - Next state: ALU_WB.
- ALU_WB: reg_write=1, mem_to_reg=00, reg_dst=01 for R else 00; → FETCH.
- MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=00; lhw→MEM_RD, shw→MEM_WR.
- MEM_RD: iord=1, mem_read=1; on mem_ready → MEM_WB.
- MEM_WB: reg_write=1, mem_to_reg=01, reg_dst=00; → FETCH.
- MEM_WR: iord=1, mem_write=1; on mem_ready → FETCH.
- BRANCH:
  - Drives alu_src_a=1, alu_src_b=00, alu_op=01, pc_src=01.
  - pc_write is combinational: beq: zero; bne: !zero; blt: lt; bgt: !lt & !zero.
  - Next state: FETCH.
- JUMP: pc_src=10, pc_write=1; → FETCH.
- Watchdog (FETCH, MEM_RD, MEM_WR):
  - wait_cnt clears on entry and increments each cycle mem_ready=0.
  - If mem_ready=0 while wait_cnt==MEM_TIMEOUT-1: set mem_timeout (cleared only by reset), suppress that cycle's completion strobes, go to FETCH.
  - mem_ready=1 in the same cycle takes priority over the timeout.
- instr_count increments on every FETCH entry from ALU_WB, MEM_WB, MEM_WR, BRANCH or JUMP. It does not increment on an illegal or timeout return. It wraps modulo 2^CNT_W.

## Timing
- Reset values: state=FETCH, op_q=0, wait_cnt=0, instr_count=0, illegal_op=0, mem_timeout=0.
  - In the first cycle after reset, outputs are FETCH values: mem_read=1, alu_src_b=01, others 0.
- Reset asserted mid-instruction returns to FETCH on the next edge. No partial write strobes appear after that edge.
- Moore outputs, except pc_write/ir_write in FETCH (mem_ready-gated) and pc_write in BRANCH (flag-gated).
- Latency with zero-wait memory:
  - R/I-type: 4 cycles
  - lhw: 5 cycles
  - shw: 4 cycles
  - branch and jump: 3 cycles
- Each memory wait cycle adds one cycle.

## Configuration
- MULTICYCLE_CONTROL_BLT_BGT_EN:
  - Defined: 1011/1100 decode to blt/bgt as above.
  - Undefined: both are illegal (illegal_op pulse, no branch), and lt is ignored.

## Test plan
- Reset, then hold mem_ready=0: outputs equal FETCH values; instr_count=0; after MEM_TIMEOUT=15 cycles, mem_timeout=1 and state=FETCH.
- R-type (0000) with mem_ready=1: reg_write=1, reg_dst=01 in cycle 4; instr_count=1 in cycle 5.
- lhw (0111), mem_ready low 3 cycles in MEM_RD: MEM_WB reached at cycle 8 with mem_to_reg=01, reg_write=1.
- beq with zero=1 → pc_write=1, pc_src=01 in cycle 3; bne with zero=1 → pc_write=0.
- With the macro defined: bgt, lt=0, zero=0 → taken; blt, lt=0 → not taken. With the macro undefined: 1011 → illegal_op pulse, instr_count unchanged.
- Opcode 0101 → illegal_op pulse in cycle 3, FETCH in cycle 3; reset asserted during MEM_WR → mem_write=0 after the edge.
